keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//   Scans one 4x4 matrix keypad and produces a debounced 4-bit key code for one player.
//   Two instances (player 1, player 2) sit directly upstream of the image generator
//   and drive its keys_1 / keys_2 inputs.
//   The key codes match those the game consumes: 2 = up, 8 = down, 5 = pause.
// PARAMETERS
//   SCAN_DIV        25000  CLOCK_25 cycles per column dwell (1 ms at 25 MHz); minimum 4
//   DEBOUNCE_SCANS  8      consecutive identical full scans required before the output changes; minimum 1
// PORTS
//   CLOCK_25   in   1  system clock, 25 MHz
//   RESET_N    in   1  synchronous reset, active low
//   rows       in   4  keypad row lines; asynchronous; active low (pulled up off-chip)
//   cols       out  4  keypad column drive; active low; exactly one bit low at any time
//   keys       out  4  debounced key code; 0 when no key is pressed
//   key_valid  out  1  1 while exactly one key is debounced-pressed; qualifies a keys value of 0
//   key_press  out  1  one-cycle pulse when a new debounced key is accepted
// BEHAVIOUR
//   - Clocking and reset: one clock (CLOCK_25); reset is synchronous, active low.
//     While RESET_N == 0 at a clock edge, all state clears:
//     cols = 4'b1110, keys = 0, key_valid = 0, key_press = 0,
//     dwell counter = 0, column index = 0, stability counter = 0, candidate = none.
//   - Row synchronisation: rows pass through a 2-flop synchroniser before any use.
//   - Column dwell: a counter runs 0 .. SCAN_DIV-1 per column.
//     When the counter is at SCAN_DIV-1, the synchronised rows are sampled for the driven column.
//     On the next cycle the column index advances 0 -> 1 -> 2 -> 3 -> 0, and cols moves its single low bit.
//   - Full scan: 4 * SCAN_DIV cycles. It ends at the sample taken for column 3.
//   - Key map (row r, column c -> code):
//       r0: 1, 2, 3, 10
//       r1: 4, 5, 6, 11
//       r2: 7, 8, 9, 12
//       r3: 14 (*), 0, 15 (#), 13
//   - Per scan: count the pressed keys (rows bit == 0) over all 4 columns and record the code of a pressed key.
//     At end of scan the scan result is:
//       NONE  if 0 keys pressed
//       KEY(code)  if exactly 1 key pressed
//       NONE  if 2 or more keys pressed (ambiguous or ghosting; never reported)
//   - Debounce: compare the scan result with the previous scan result.
//       equal     -> stability counter + 1, saturating at DEBOUNCE_SCANS
//       not equal -> stability counter = 1
//     When the counter reaches DEBOUNCE_SCANS and the result differs from the current output:
//       KEY(c): keys = c, key_valid = 1, key_press = 1 for exactly that cycle
//       NONE:   keys = 0, key_valid = 0, no pulse
//   - Direct key change (KEY(a) stable -> KEY(b) stable): keys switches to b and key_press pulses again.
//   - Latency: the output updates on the cycle after the end-of-scan sample of the DEBOUNCE_SCANS-th
//     identical scan. The worst case after the rows settle is (DEBOUNCE_SCANS + 1) * 4 * SCAN_DIV + 3 cycles.
//   - keys and key_valid change only at those update points; they are stable between them.
//   - Reset mid-scan or mid-debounce discards the partial scan and the stability count.
//   - All counters are sized with $clog2 of their maximum; none wraps except the dwell counter
//     and the column index.
// TESTING (bench uses SCAN_DIV = 4, DEBOUNCE_SCANS = 3)
//   1. Hold RESET_N = 0 for 5 cycles, rows = 4'hF
//        -> cols = 4'b1110, keys = 0, key_valid = 0, key_press = 0 throughout.
//      Release reset -> cols walks 1110, 1101, 1011, 0111, changing every 4 cycles.
//   2. Press '5' (row 1 low while cols[1] = 0) and hold
//        -> after 3 full scans: keys = 5, key_valid = 1, key_press high for exactly 1 cycle.
//      Release -> 3 scans later: keys = 0, key_valid = 0.
//   3. Bounce '8': pressed and released on alternate scans for 10 scans
//        -> keys, key_valid and key_press never change.
//   4. Hold '2' and '8' together -> keys = 0, key_valid = 0.
//      Then release '8' -> 3 scans later: keys = 2, one key_press pulse.
//   5. Press '0' (row 3, col 1) -> keys = 0, key_valid = 1, one key_press pulse.
//      Then slide directly to '#' -> keys = 15, a second key_press pulse.
//   6. Press '2', and after 2 stable scans assert RESET_N = 0 for 1 cycle with '2' still held
//        -> outputs return to reset values; keys = 2 again only 3 full scans after reset release.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, counts pressed keys per
// full scan and debounces the single-key result into a registered key code.
`timescale 1ns/1ps

module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 25000,
    parameter int unsigned DEBOUNCE_SCANS = 8
) (
    input  logic       CLOCK_25,
    input  logic       RESET_N,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] keys,
    output logic       key_valid,
    output logic       key_press
);

    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam int unsigned SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STAB_MAX   = SW'(DEBOUNCE_SCANS);

    logic [3:0]    r_rows_meta;
    logic [3:0]    r_rows_sync;
    logic [DW-1:0] r_dwell;
    logic [1:0]    r_col;
    logic [3:0]    r_cols;
    logic [1:0]    r_cnt;
    logic [3:0]    r_code;
    logic          r_cand_valid;
    logic [3:0]    r_cand_code;
    logic [SW-1:0] r_stab;
    logic [3:0]    r_keys;
    logic          r_key_valid;
    logic          r_key_press;

    logic [3:0]    w_pressed;
    logic [2:0]    w_col_cnt;
    logic [3:0]    w_col_code;
    logic          w_col_hit;
    logic [2:0]    w_tot;
    logic [1:0]    w_cnt_sat;
    logic [3:0]    w_code_acc;
    logic          w_res_valid;
    logic [3:0]    w_res_code;
    logic          w_res_same;
    logic          w_res_new;
    logic [SW-1:0] w_stab_next;
    logic          w_dwell_end;
    logic          w_scan_end;

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'd1;
            4'h1: code = 4'd2;
            4'h2: code = 4'd3;
            4'h3: code = 4'd10;
            4'h4: code = 4'd4;
            4'h5: code = 4'd5;
            4'h6: code = 4'd6;
            4'h7: code = 4'd11;
            4'h8: code = 4'd7;
            4'h9: code = 4'd8;
            4'hA: code = 4'd9;
            4'hB: code = 4'd12;
            4'hC: code = 4'd14;
            4'hD: code = 4'd0;
            4'hE: code = 4'd15;
            default: code = 4'd13;
        endcase
        return code;
    endfunction

    assign w_dwell_end = (r_dwell == DWELL_LAST);
    assign w_scan_end  = w_dwell_end && (r_col == 2'd3);

    always_comb begin
        w_pressed  = ~r_rows_sync;
        w_col_cnt  = '0;
        w_col_code = '0;
        w_col_hit  = 1'b0;
        for (int r = 0; r < 4; r++) begin
            if (w_pressed[r]) begin
                w_col_cnt  = w_col_cnt + 3'd1;
                w_col_code = key_map(2'(r), r_col);
                w_col_hit  = 1'b1;
            end
        end
        // Key count saturates at 2: anything beyond one key is already ambiguous.
        w_tot       = w_col_cnt + {1'b0, r_cnt};
        w_cnt_sat   = (w_tot >= 3'd2) ? 2'd2 : w_tot[1:0];
        w_code_acc  = w_col_hit ? w_col_code : r_code;
        w_res_valid = (w_cnt_sat == 2'd1);
        w_res_code  = w_res_valid ? w_code_acc : 4'd0;
        w_res_same  = ({w_res_valid, w_res_code} == {r_cand_valid, r_cand_code});
        w_res_new   = ({w_res_valid, w_res_code} != {r_key_valid, r_keys});
        if (!w_res_same) begin
            w_stab_next = SW'(1);
        end else if (r_stab == STAB_MAX) begin
            w_stab_next = r_stab;
        end else begin
            w_stab_next = r_stab + SW'(1);
        end
    end

    always_ff @(posedge CLOCK_25) begin
        if (!RESET_N) begin
            r_rows_meta  <= 4'hF;
            r_rows_sync  <= 4'hF;
            r_dwell      <= '0;
            r_col        <= 2'd0;
            r_cols       <= 4'b1110;
            r_cnt        <= 2'd0;
            r_code       <= 4'd0;
            r_cand_valid <= 1'b0;
            r_cand_code  <= 4'd0;
            r_stab       <= '0;
            r_keys       <= 4'd0;
            r_key_valid  <= 1'b0;
            r_key_press  <= 1'b0;
        end else begin
            r_rows_meta <= rows;
            r_rows_sync <= r_rows_meta;
            r_key_press <= 1'b0;
            if (w_dwell_end) begin
                r_dwell <= '0;
                r_col   <= r_col + 2'd1;
                r_cols  <= {r_cols[2:0], r_cols[3]};
                if (w_scan_end) begin
                    r_cnt        <= 2'd0;
                    r_code       <= 4'd0;
                    r_cand_valid <= w_res_valid;
                    r_cand_code  <= w_res_code;
                    r_stab       <= w_stab_next;
                    if ((w_stab_next == STAB_MAX) && w_res_new) begin
                        r_keys      <= w_res_code;
                        r_key_valid <= w_res_valid;
                        r_key_press <= w_res_valid;
                    end
                end else begin
                    r_cnt  <= w_cnt_sat;
                    r_code <= w_code_acc;
                end
            end else begin
                r_dwell <= r_dwell + DW'(1);
            end
        end
    end

    assign cols      = r_cols;
    assign keys      = r_keys;
    assign key_valid = r_key_valid;
    assign key_press = r_key_press;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model pulls rows low for held keys on the
// driven column; checks are placed on full-scan boundaries with hand-computed outcomes.
`timescale 1ns/1ps

module tb_keypad_scanner;

    localparam int unsigned SD   = 4;
    localparam int unsigned DB   = 3;
    localparam int unsigned SCAN = 4 * SD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  keys;
    logic        key_valid;
    logic        key_press;
    logic [15:0] pressed;

    int passed    = 0;
    int total     = 0;
    int ecount    = 0;
    int press_cnt = 0;

    // Key index bits are row*4 + col
    localparam int K5 = 5;
    localparam int K8 = 9;
    localparam int K2 = 1;
    localparam int K0 = 13;
    localparam int KH = 14;

    keypad_scanner #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .CLOCK_25  (clk),
        .RESET_N   (rst_n),
        .rows      (rows),
        .cols      (cols),
        .keys      (keys),
        .key_valid (key_valid),
        .key_press (key_press)
    );

    always #5 clk = ~clk;

    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            rows[r] = ~|(pressed[r*4 +: 4] & ~cols);
        end
    end

    always @(negedge clk) begin
        if (key_press === 1'b1) press_cnt <= press_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        ecount = ecount + 1;
    endtask

    task automatic scans(input int n);
        repeat (SCAN * n) step();
    endtask

    task automatic to_boundary();
        while (ecount % SCAN != 0) step();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic check_out(input string tag, input logic [3:0] k, input logic v,
                             input logic p);
        chk({tag, "_keys"}, {4'h0, keys}, {4'h0, k});
        chk({tag, "_valid"}, {7'h0, key_valid}, {7'h0, v});
        chk({tag, "_press"}, {7'h0, key_press}, {7'h0, p});
    endtask

    task automatic pulse(input string tag, input logic [3:0] k);
        check_out(tag, k, 1'b1, 1'b1);
        step();
        check_out({tag, "_after"}, k, 1'b1, 1'b0);
        to_boundary();
    endtask

    initial begin
        logic [3:0] one;
        logic [3:0] exp_cols;
        one     = 4'b0001;
        rst_n   = 1'b0;
        pressed = '0;

        // Reset held for five cycles
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_cols", {4'h0, cols}, 8'h0E);
            check_out("rst", 4'd0, 1'b0, 1'b0);
        end
        rst_n  = 1'b1;
        ecount = 0;

        // Column walk over one full scan
        for (int e = 1; e <= 16; e++) begin
            step();
            exp_cols = ~(one << ((e / SD) % 4));
            chk("walk_cols", {4'h0, cols}, {4'h0, exp_cols});
        end

        // Press '5', hold, release
        pressed[K5] = 1'b1;
        scans(DB - 1);
        check_out("p5_early", 4'd0, 1'b0, 1'b0);
        scans(1);
        pulse("p5", 4'd5);
        pressed = '0;
        scans(DB - 1);
        check_out("r5_early", 4'd5, 1'b1, 1'b0);
        scans(1);
        check_out("r5", 4'd0, 1'b0, 1'b0);

        // Bouncing '8' never settles
        for (int i = 0; i < 10; i++) begin
            pressed[K8] = (i % 2 == 0);
            scans(1);
            check_out("bounce", 4'd0, 1'b0, 1'b0);
        end
        pressed = '0;
        chk("bounce_cnt", press_cnt[7:0], 8'd1);

        // '2' and '8' together are ambiguous, then '2' alone
        pressed[K2] = 1'b1;
        pressed[K8] = 1'b1;
        scans(DB);
        check_out("dual", 4'd0, 1'b0, 1'b0);
        pressed[K8] = 1'b0;
        scans(DB - 1);
        check_out("p2_early", 4'd0, 1'b0, 1'b0);
        scans(1);
        pulse("p2", 4'd2);

        // '0' reports code 0 with valid, then slide to '#'
        pressed = '0;
        scans(DB);
        check_out("r2", 4'd0, 1'b0, 1'b0);
        pressed[K0] = 1'b1;
        scans(DB - 1);
        check_out("p0_early", 4'd0, 1'b0, 1'b0);
        scans(1);
        pulse("p0", 4'd0);
        pressed[K0] = 1'b0;
        pressed[KH] = 1'b1;
        scans(DB - 1);
        check_out("ph_early", 4'd0, 1'b1, 1'b0);
        scans(1);
        pulse("ph", 4'd15);
        chk("cnt_mid", press_cnt[7:0], 8'd4);

        // Reset mid-debounce discards the stability count
        pressed = '0;
        scans(DB);
        check_out("rh", 4'd0, 1'b0, 1'b0);
        pressed[K2] = 1'b1;
        scans(DB - 1);
        check_out("p2r_pre", 4'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        chk("mid_rst_cols", {4'h0, cols}, 8'h0E);
        check_out("mid_rst", 4'd0, 1'b0, 1'b0);
        rst_n  = 1'b1;
        ecount = 0;
        scans(1);
        check_out("p2r_s1", 4'd0, 1'b0, 1'b0);
        scans(DB - 2);
        check_out("p2r_early", 4'd0, 1'b0, 1'b0);
        scans(1);
        pulse("p2r", 4'd2);
        chk("cnt_end", press_cnt[7:0], 8'd5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
